// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU port and the IO/DMA port, with bounded locked IO bursts.
// Optional build macro DMEM_ARB_ROUND_ROBIN_EN: round-robin on ARB contention instead of fixed CPU priority.
module dmem_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic              io_lock,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] io_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic {ARB, IO_BURST} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_IO} owner_e;
  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);
  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [7:0] cnt_q, cnt_d;
  logic       cpu_pri;
  logic       burst_full;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_io_q, last_io_d;
  assign cpu_pri = last_io_q;
  // Only contention resolved in ARB moves the round-robin pointer.
  always_comb last_io_d = (state_q == ARB && cpu_req && io_req) ? io_gnt : last_io_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_io_q <= 1'b1;
    else        last_io_q <= last_io_d;
  end
`else
  assign cpu_pri = 1'b1;
`endif
  assign burst_full = cnt_q == MAX_CNT;
  // In a burst the CPU only gets in when IO idles or the burst budget is spent.
  always_comb begin
    cpu_gnt    = rst_n && cpu_req && (!io_req || (state_q == IO_BURST ? burst_full : cpu_pri));
    io_gnt     = rst_n && io_req && !cpu_gnt;
    mem_we     = cpu_gnt ? cpu_we : io_gnt && io_we;
    mem_en     = cpu_gnt ? !cpu_we : io_gnt && !io_we;
    mem_addr   = cpu_gnt ? cpu_addr : io_gnt ? io_addr : '0;
    mem_wdata  = cpu_gnt ? cpu_wdata : io_gnt ? io_wdata : '0;
    cpu_rvalid = owner_q == OWN_CPU;
    io_rvalid  = owner_q == OWN_IO;
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    io_rdata   = io_rvalid ? mem_rdata : '0;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = (cpu_gnt && !cpu_we) ? OWN_CPU : (io_gnt && !io_we) ? OWN_IO : OWN_NONE;
    if (io_gnt && io_lock) begin
      state_d = IO_BURST;
      cnt_d   = state_q == ARB ? 8'd1 : burst_full ? cnt_q : cnt_q + 8'd1;
    end else if (cpu_gnt || io_gnt || !io_req) begin
      state_d = ARB;
      cnt_d   = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      cnt_q   <= '0;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (14-bit word address, 32-bit data, registered read) between two requesters: the CPU load/store pipeline (CPU port) and the IO/DMA engine (IO port).
- Sits directly in front of the data memory. It drives the memory's en/we/addr/wdata and returns read data to the requester that issued the read.
- Supports locked IO bursts, bounded so that the CPU cannot starve.

Parameters:
- ADDR_W, 14, word address width; matches data memory depth of 16384.
- DATA_W, 32, data width.
- MAX_BURST, 8, maximum consecutive IO grants under lock before a forced CPU slot; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  request accepted this cycle (combinational).
- cpu_rvalid  out  1  cpu_rdata valid this cycle.
- cpu_rdata  out  DATA_W  read data to CPU.
- io_req  in  1  IO access request.
- io_we  in  1  1 = write, 0 = read.
- io_lock  in  1  keep ownership for the next beat (burst).
- io_addr  in  ADDR_W  IO word address.
- io_wdata  in  DATA_W  IO write data.
- io_gnt  out  1  IO request accepted this cycle (combinational).
- io_rvalid  out  1  io_rdata valid this cycle.
- io_rdata  out  DATA_W  read data to IO.
- mem_en  out  1  memory read enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_en.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is ARB; burst counter is 0; rsp_owner is NONE; last-winner is IO.
  - All gnt/rvalid outputs are 0. mem_en = mem_we = 0. mem_addr and mem_wdata are 0.
- Handshake:
  - A request is accepted in the cycle where req and gnt are both 1.
  - A requester holds req, we, addr and wdata stable until granted.
  - At most one gnt is asserted per cycle. gnt is never asserted without the matching req.
- Memory drive (combinational from the winner):
  - mem_addr and mem_wdata are the winner's signals.
  - mem_we = winner's we.
  - mem_en = winner's !we.
  - With no winner, mem_en = mem_we = 0.
- Read return, 1-cycle latency:
  - On an accepted read, rsp_owner is registered as the winner.
  - Next cycle, the owner's rvalid = 1 and its rdata = mem_rdata. The other port's rdata is 0.
  - Writes produce no rvalid.
  - Back-to-back reads alternating between owners return correctly every cycle.
- States:
  - ARB:
    - Only one req high: that port wins.
    - Both high: the priority rule applies (see Optional Feature).
    - IO wins with io_lock = 1: go to IO_BURST with count = 1.
  - IO_BURST:
    - IO has exclusive priority, including when both request.
    - Each IO grant with io_lock = 1 increments count.
    - An IO grant with io_lock = 0 ends the burst: go to ARB.
    - io_req low for a cycle: return to ARB, and the CPU may win that same cycle.
    - count == MAX_BURST with cpu_req high: the CPU is granted that cycle and the state returns to ARB.
    - count == MAX_BURST with cpu_req low: IO continues and count saturates.
- Simultaneous events:
  - A write and a read to the same address in consecutive cycles return the new data, because the memory writes at posedge before the next read.
- Reset mid-operation: a pending rvalid is dropped, not delivered after reset.

Optional Feature:
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- Defined: on contention in ARB, the port that did not win the most recent contended grant wins. Last-winner resets to IO, so the first contention goes to the CPU.
- Undefined: fixed priority, CPU always wins contention in ARB. The last-winner register is not built.
- IO_BURST behaviour is identical in both builds.

Test Plan:
- CPU write 0xDEADBEEF to addr 0x0010, then CPU read 0x0010 → cpu_gnt = 1 both cycles; cpu_rvalid = 1 one cycle after the read with cpu_rdata = 0xDEADBEEF; io_rvalid stays 0.
- Both request reads every cycle (CPU addr 0x0001 holding 0x11, IO addr 0x0002 holding 0x22):
  - Fixed build: cpu_gnt every cycle, io_gnt never.
  - ROUND_ROBIN build: grants alternate CPU, IO, CPU…; rvalid/rdata are routed to the matching port each following cycle.
- IO locked burst, MAX_BURST = 4, io_lock = 1 for 10 beats, cpu_req high throughout → 4 io_gnt, then 1 cpu_gnt, then IO resumes.
- IO burst of 3 with io_lock deasserted on beat 3, cpu_req high → cpu_gnt in the cycle after beat 3.
- Assert rst_n = 0 in the cycle after an accepted IO read → io_rvalid = 0, mem_en = 0, all gnt = 0 immediately; after release, a normal CPU read succeeds.
- IO writes 0x5A5A5A5A to 0x3FFF and CPU reads 0x3FFF the next cycle → cpu_rdata = 0x5A5A5A5A, confirming top-address access and the write-then-read ordering.
